decoder_seq: RTL and testbench



---
 rtl/decoder_seq_if.sv | 28 ++
 rtl/decoder_seq.sv | 102 ++++++++++
 tb/tb_decoder_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/decoder_seq_if.sv
// decoder_seq_if: request/response bundle for decoder_seq.
//   IN_VALID / IN_READY : request handshake, SEL and MODE qualify a request
//   X / X_VALID / X_READY / X_LAST : decoded-word stream towards the consumer
// master = requester/consumer side, slave = decoder side.
interface decoder_seq_if #(
    parameter int N = 3
) ();
    localparam int W = 1 << N;

    logic          IN_VALID;
    logic          IN_READY;
    logic [N-1:0]  SEL;
    logic [1:0]    MODE;
    logic [W-1:0]  X;
    logic          X_VALID;
    logic          X_READY;
    logic          X_LAST;

    modport master (
        output IN_VALID, SEL, MODE, X_READY,
        input  IN_READY, X, X_VALID, X_LAST
    );

    modport slave (
        input  IN_VALID, SEL, MODE, X_READY,
        output IN_READY, X, X_VALID, X_LAST
    );
endinterface

// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2^N decoder with valid/ready flow control.
//   CLK     rising-edge clock
//   RST     asynchronous active-high reset
//   bus     decoder_seq_if.slave:
//           IN_VALID/IN_READY/SEL/MODE request, X/X_VALID/X_READY/X_LAST word
// MODE: 00/11 one-hot, 01 thermometer, 10 scan (one-hot walk SEL..W-1).
// ACT_LOW inverts X only; handshake flags keep their polarity.
module decoder_seq #(
    parameter int N       = 3,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    decoder_seq_if.slave bus
);
    localparam int W = 1 << N;
    localparam logic [W-1:0] INACTIVE = {W{ACT_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WORD,
        ST_SCAN
    } state_t;

    state_t        state;
    logic          xValid;
    logic          xLast;
    logic [W-1:0]  xReg;
    logic [N-1:0]  cnt;

    logic          inReady;
    logic          accept;
    logic          pop;
    logic [N-1:0]  cntNext;

    function automatic logic [W-1:0] oneHot(input logic [N-1:0] s);
        oneHot = {{(W-1){1'b0}}, 1'b1} << s;
    endfunction

    // Bits strictly below s, plus bit s itself.
    function automatic logic [W-1:0] thermo(input logic [N-1:0] s);
        thermo = ~({W{1'b1}} << s) | oneHot(s);
    endfunction

    function automatic logic [W-1:0] pol(input logic [W-1:0] w);
        pol = ACT_LOW ? ~w : w;
    endfunction

    always_comb begin
        // A new request may land on the same edge the final word leaves.
        inReady = !xValid | (bus.X_READY & xLast);
        accept  = bus.IN_VALID & inReady;
        pop     = xValid & bus.X_READY;
        cntNext = cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            xValid <= 1'b0;
            xLast  <= 1'b0;
            xReg   <= INACTIVE;
            cnt    <= '0;
        end else if (accept) begin
            xValid <= 1'b1;
            case (bus.MODE)
                2'b01: begin
                    state <= ST_WORD;
                    xReg  <= pol(thermo(bus.SEL));
                    xLast <= 1'b1;
                end
                2'b10: begin
                    state <= ST_SCAN;
                    cnt   <= bus.SEL;
                    xReg  <= pol(oneHot(bus.SEL));
                    xLast <= &bus.SEL;
                end
                default: begin
                    state <= ST_WORD;
                    xReg  <= pol(oneHot(bus.SEL));
                    xLast <= 1'b1;
                end
            endcase
        end else if (pop) begin
            if (state == ST_SCAN && !xLast) begin
                cnt   <= cntNext;
                xReg  <= pol(oneHot(cntNext));
                xLast <= &cntNext;
            end else begin
                state  <= ST_IDLE;
                xValid <= 1'b0;
                xLast  <= 1'b0;
                xReg   <= INACTIVE;
            end
        end
    end

    assign bus.IN_READY = inReady;
    assign bus.X        = xReg;
    assign bus.X_VALID  = xValid;
    assign bus.X_LAST   = xLast;
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: drives an active-high and an active-low decoder_seq with
// identical directed stimulus; a queue-of-words model predicts every cycle.
module tb_decoder_seq;
    localparam int N = 3;
    localparam int W = 1 << N;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid;
    logic [N-1:0]  sel;
    logic [1:0]    mode;
    logic          xReady;

    decoder_seq_if #(.N(N)) busLo ();
    decoder_seq_if #(.N(N)) busHi ();

    assign busLo.IN_VALID = inValid;
    assign busLo.SEL      = sel;
    assign busLo.MODE     = mode;
    assign busLo.X_READY  = xReady;
    assign busHi.IN_VALID = inValid;
    assign busHi.SEL      = sel;
    assign busHi.MODE     = mode;
    assign busHi.X_READY  = xReady;

    decoder_seq #(.N(N), .ACT_LOW(1'b0)) dutLo (.CLK(clk), .RST(rst), .bus(busLo));
    decoder_seq #(.N(N), .ACT_LOW(1'b1)) dutHi (.CLK(clk), .RST(rst), .bus(busHi));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted request expands into its list of words;
    // the head of the list is what X must show.
    typedef struct {
        logic [W-1:0] word;
        logic         last;
    } item_t;

    item_t q[$];
    bit    mRdy;

    function automatic void pushReq(input logic [N-1:0] s, input logic [1:0] m);
        int unsigned sv;
        sv = s;
        if (m == 2'b10) begin
            for (int unsigned j = sv; j < W; j++)
                q.push_back('{word: W'(1) << j, last: (j == W - 1)});
        end else if (m == 2'b01) begin
            q.push_back('{word: W'((1 << (sv + 1)) - 1), last: 1'b1});
        end else begin
            q.push_back('{word: W'(1) << sv, last: 1'b1});
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            mRdy = (q.size() == 0) || (xReady && q.size() == 1);
            if (q.size() != 0 && xReady) void'(q.pop_front());
            if (inValid && mRdy) pushReq(sel, mode);
        end
    end

    logic [W-1:0] eW;
    logic         eV, eL, eR;

    always @(negedge clk) begin
        eV = (q.size() != 0);
        eW = eV ? q[0].word : '0;
        eL = eV ? q[0].last : 1'b0;
        eR = (q.size() == 0) || (xReady && q.size() == 1);
        chk("cmpXLo",   busLo.X, eW);
        chk("cmpXHi",   busHi.X, ~eW);
        chk("cmpVldLo", W'(busLo.X_VALID), W'(eV));
        chk("cmpVldHi", W'(busHi.X_VALID), W'(eV));
        chk("cmpLstLo", W'(busLo.X_LAST), W'(eL));
        chk("cmpLstHi", W'(busHi.X_LAST), W'(eL));
        chk("cmpRdyLo", W'(busLo.IN_READY), W'(eR));
        chk("cmpRdyHi", W'(busHi.IN_READY), W'(eR));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ohTab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [2:0] thSel [3] = '{3'd5, 3'd0, 3'd7};
    logic [7:0] thTab [3] = '{8'h3F, 8'h01, 8'hFF};
    logic [7:0] stTab [4] = '{8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        rst = 1'b1; inValid = 1'b0; sel = '0; mode = 2'b00; xReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rstVld", W'(busLo.X_VALID), 8'h00);
        chk("rstXLo", busLo.X, 8'h00);
        chk("rstXHi", busHi.X, 8'hFF);
        chk("rstRdy", W'(busLo.IN_READY), 8'h01);
        #2 rst = 1'b0;

        // One-hot back-to-back, alternating MODE 00 and 11.
        for (int i = 0; i < W; i++) begin
            inValid = 1'b1; sel = N'(i); mode = (i % 2 == 1) ? 2'b11 : 2'b00;
            step();
            chk("ohX", busLo.X, ohTab[i]);
            chk("ohVld", W'(busLo.X_VALID), 8'h01);
            chk("ohLast", W'(busLo.X_LAST), 8'h01);
        end
        inValid = 1'b0;
        step();
        chk("ohIdle", W'(busLo.X_VALID), 8'h00);

        // Active-low one-hot.
        inValid = 1'b1; sel = 3'd3; mode = 2'b00;
        step();
        chk("alX", busHi.X, 8'hF7);
        chk("alVld", W'(busHi.X_VALID), 8'h01);
        inValid = 1'b0;
        step();
        chk("alIdle", busHi.X, 8'hFF);

        // Thermometer back-to-back.
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1; sel = thSel[i]; mode = 2'b01;
            step();
            chk("thX", busLo.X, thTab[i]);
        end
        inValid = 1'b0;
        step();

        // Scan from 5 with a queued one-hot request behind it.
        inValid = 1'b1; sel = 3'd5; mode = 2'b10;
        step();
        chk("sc5X0", busLo.X, 8'h20);
        chk("sc5L0", W'(busLo.X_LAST), 8'h00);
        chk("sc5R0", W'(busLo.IN_READY), 8'h00);
        sel = 3'd1; mode = 2'b00;
        step();
        chk("sc5X1", busLo.X, 8'h40);
        chk("sc5R1", W'(busLo.IN_READY), 8'h00);
        step();
        chk("sc5X2", busLo.X, 8'h80);
        chk("sc5L2", W'(busLo.X_LAST), 8'h01);
        chk("sc5R2", W'(busLo.IN_READY), 8'h01);
        step();
        chk("sc5Next", busLo.X, 8'h02);
        inValid = 1'b0;
        step();
        chk("sc5Idle", W'(busLo.X_VALID), 8'h00);

        // Scan from 2 with a 3-cycle stall after the second word.
        inValid = 1'b1; sel = 3'd2; mode = 2'b10;
        step();
        chk("sc2X0", busLo.X, 8'h04);
        inValid = 1'b0; sel = 3'd7; mode = 2'b01;
        step();
        chk("sc2X1", busLo.X, 8'h08);
        xReady = 1'b0;
        repeat (3) begin
            step();
            chk("sc2Hold", busLo.X, 8'h08);
            chk("sc2HoldL", W'(busLo.X_LAST), 8'h00);
        end
        xReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sc2Run", busLo.X, stTab[i]);
        end
        chk("sc2Last", W'(busLo.X_LAST), 8'h01);
        step();
        chk("sc2Idle", W'(busLo.X_VALID), 8'h00);

        // Asynchronous reset mid-scan at CNT=4.
        inValid = 1'b1; sel = 3'd0; mode = 2'b10;
        step();
        inValid = 1'b0;
        repeat (4) step();
        chk("arX", busLo.X, 8'h10);
        #2 rst = 1'b1;
        #1;
        chk("arVld", W'(busLo.X_VALID), 8'h00);
        chk("arXLo", busLo.X, 8'h00);
        chk("arXHi", busHi.X, 8'hFF);
        chk("arRdy", W'(busLo.IN_READY), 8'h01);
        @(posedge clk);
        #3 rst = 1'b0;
        chk("arRdy2", W'(busLo.IN_READY), 8'h01);
        inValid = 1'b1; sel = 3'd6; mode = 2'b00;
        step();
        chk("arNewX", busLo.X, 8'h40);
        chk("arNewV", W'(busLo.X_VALID), 8'h01);
        inValid = 1'b0;
        step();
        chk("arEnd", W'(busLo.X_VALID), 8'h00);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
